// File: rtl/bus_rr.sv
// bus_rr: round-robin N-host/M-device interconnect; grant is combinational, response one cycle after grant.
// No backpressure: one transaction per cycle. BUS_RR_DECODE_ERR_EN turns unmatched addresses into decode-error responses.
module bus_rr #(
    parameter int NrHosts      = 2,
    parameter int NrDevices    = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    host_req_i     [NrHosts],
    input  logic                    host_we_i      [NrHosts],
    input  logic [DataWidth/8-1:0]  host_be_i      [NrHosts],
    input  logic [AddressWidth-1:0] host_addr_i    [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i   [NrHosts],
    output logic                    host_gnt_o     [NrHosts],
    output logic                    host_rvalid_o  [NrHosts],
    output logic [DataWidth-1:0]    host_rdata_o   [NrHosts],
    output logic                    host_err_o     [NrHosts],
    output logic                    device_req_o   [NrDevices],
    output logic                    device_we_o    [NrDevices],
    output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
    output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
    output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
    input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

    localparam int HW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DVW = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic [HW-1:0]  r_rr_ptr;
    logic           r_resp_valid;
    logic [HW-1:0]  r_resp_host;
    logic [DVW-1:0] r_resp_dev;

    logic           w_gnt_vld;
    logic [HW-1:0]  w_win;
    int             w_idx;
    logic           w_match;
    logic [DVW-1:0] w_dev;
    logic           w_route;
    logic           w_resp_err;

    // Scan upward from the pointer with wrap; first requester wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_win     = '0;
        w_idx     = 0;
        for (int off = 0; off < NrHosts; off++) begin
            w_idx = int'(r_rr_ptr) + off;
            if (w_idx >= NrHosts) begin
                w_idx = w_idx - NrHosts;
            end
            if (!w_gnt_vld && host_req_i[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_win     = HW'(w_idx);
            end
        end
    end

    always_comb begin
        w_match = 1'b0;
        w_dev   = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (!w_match &&
                ((host_addr_i[w_win] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
                w_match = 1'b1;
                w_dev   = DVW'(d);
            end
        end
    end

`ifdef BUS_RR_DECODE_ERR_EN
    logic r_resp_err;
    logic w_err;

    assign w_route    = w_gnt_vld & w_match;
    assign w_err      = w_gnt_vld & ~w_match;
    assign w_resp_err = r_resp_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_err <= 1'b0;
        end else if (w_gnt_vld) begin
            r_resp_err <= w_err;
        end
    end
`else
    // Unmatched addresses fall through to device 0 (w_dev defaults to 0).
    assign w_route    = w_gnt_vld;
    assign w_resp_err = 1'b0;
`endif

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = w_gnt_vld && (w_win == HW'(h));
        end
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = 1'b0;
            device_we_o[d]    = 1'b0;
            device_be_o[d]    = '0;
            device_addr_o[d]  = '0;
            device_wdata_o[d] = '0;
            if (w_route && (w_dev == DVW'(d))) begin
                device_req_o[d]   = 1'b1;
                device_we_o[d]    = host_we_i[w_win];
                device_be_o[d]    = host_be_i[w_win];
                device_addr_o[d]  = host_addr_i[w_win];
                device_wdata_o[d] = host_wdata_i[w_win];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_host  <= '0;
            r_resp_dev   <= '0;
        end else begin
            r_resp_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_rr_ptr    <= (w_win == HW'(NrHosts - 1)) ? '0 : w_win + 1'b1;
                r_resp_host <= w_win;
                r_resp_dev  <= w_dev;
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = 1'b0;
            host_rdata_o[h]  = '0;
            host_err_o[h]    = 1'b0;
            if (r_resp_valid && (r_resp_host == HW'(h))) begin
                host_rvalid_o[h] = 1'b1;
                host_rdata_o[h]  = w_resp_err ? '0 : device_rdata_i[r_resp_dev];
                host_err_o[h]    = w_resp_err;
            end
        end
    end

endmodule

// File: tb/tb_bus_rr.sv
// Directed bench for bus_rr with 3 hosts and 2 devices (device0 at 0x0000_xxxx, device1 at 0x0001_xxxx).
// Expectations follow the decode-error build option when BUS_RR_DECODE_ERR_EN is defined.
module tb_bus_rr;

    localparam int NH = 3;
    localparam int ND = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_req    [NH];
    logic          host_we     [NH];
    logic [DW/8-1:0] host_be   [NH];
    logic [AW-1:0] host_addr   [NH];
    logic [DW-1:0] host_wdata  [NH];
    logic          host_gnt    [NH];
    logic          host_rvalid [NH];
    logic [DW-1:0] host_rdata  [NH];
    logic          host_err    [NH];
    logic          dev_req     [ND];
    logic          dev_we      [ND];
    logic [DW/8-1:0] dev_be    [ND];
    logic [AW-1:0] dev_addr    [ND];
    logic [DW-1:0] dev_wdata   [ND];
    logic [DW-1:0] dev_rdata   [ND];
    logic [AW-1:0] cfg_base    [ND];
    logic [AW-1:0] cfg_mask    [ND];

    logic [NH-1:0] gnt_v, rvalid_v, err_v;
    logic [ND-1:0] dreq_v;
    logic [DW-1:0] rdata_or;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar h = 0; h < NH; h++) begin : g_pk
        assign gnt_v[h]    = host_gnt[h];
        assign rvalid_v[h] = host_rvalid[h];
        assign err_v[h]    = host_err[h];
    end
    assign dreq_v   = {dev_req[1], dev_req[0]};
    assign rdata_or = host_rdata[0] | host_rdata[1] | host_rdata[2];

    bus_rr #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
        .host_rdata_o(host_rdata), .host_err_o(host_err),
        .device_req_o(dev_req), .device_we_o(dev_we), .device_be_o(dev_be),
        .device_addr_o(dev_addr), .device_wdata_o(dev_wdata),
        .device_rdata_i(dev_rdata),
        .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
    );

    task automatic idle();
        for (int h = 0; h < NH; h++) begin
            host_req[h]   = 1'b0;
            host_we[h]    = 1'b0;
            host_be[h]    = '0;
            host_addr[h]  = '0;
            host_wdata[h] = '0;
        end
        for (int d = 0; d < ND; d++) dev_rdata[d] = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({gnt_v, rvalid_v, err_v, dreq_v} !== '0 || rdata_or !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b rv=%b err=%b dreq=%b rdata=%h exp all 0",
                     gnt_v, rvalid_v, err_v, dreq_v, rdata_or);
        end
        do_reset();
        #1;
        checks++;
        if ({gnt_v, rvalid_v, err_v, dreq_v} !== '0) begin
            errors++;
            $display("FAIL reset_release got gnt=%b rv=%b err=%b dreq=%b exp all 0",
                     gnt_v, rvalid_v, err_v, dreq_v);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        host_req[0]  = 1'b1;
        host_addr[0] = 32'h0001_0004;
        dev_rdata[1] = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (gnt_v !== 3'b001 || dreq_v !== 2'b10 || dev_addr[1] !== 32'h0001_0004 || dev_we[1] !== 1'b0) begin
            errors++;
            $display("FAIL read_req got gnt=%b dreq=%b addr=%h we=%b exp gnt=001 dreq=10 addr=00010004 we=0",
                     gnt_v, dreq_v, dev_addr[1], dev_we[1]);
        end
        @(posedge clk);
        #1;
        host_req[0] = 1'b0;
        #1;
        checks++;
        if (rvalid_v !== 3'b001 || host_rdata[0] !== 32'hDEAD_BEEF || err_v !== 3'b000) begin
            errors++;
            $display("FAIL read_resp got rv=%b rdata=%h err=%b exp rv=001 rdata=deadbeef err=000",
                     rvalid_v, host_rdata[0], err_v);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rvalid_v !== 3'b000) begin
            errors++;
            $display("FAIL read_rvalid_drop got %b exp 000", rvalid_v);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [NH-1:0] exp_oh;
        do_reset();
        dev_rdata[0] = 32'h1234_5678;
        for (int h = 0; h < NH; h++) begin
            host_req[h]  = 1'b1;
            host_addr[h] = 32'h0000_0010 + 32'(h * 4);
        end
        for (int i = 0; i < 6; i++) begin
            exp_oh = 3'b001 << (i % 3);
            #1;
            checks++;
            if (gnt_v !== exp_oh) begin
                errors++;
                $display("FAIL fair_gnt[%0d] got %b exp %b", i, gnt_v, exp_oh);
            end
            @(posedge clk);
            #1;
            checks++;
            if (rvalid_v !== exp_oh || host_rdata[i % 3] !== 32'h1234_5678) begin
                errors++;
                $display("FAIL fair_resp[%0d] got rv=%b rdata=%h exp rv=%b rdata=12345678",
                         i, rvalid_v, host_rdata[i % 3], exp_oh);
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_ptr_skip();
        do_reset();
        host_req[0] = 1'b1;
        #1;
        checks++;
        if (gnt_v !== 3'b001) begin
            errors++;
            $display("FAIL skip_setup got %b exp 001", gnt_v);
        end
        @(negedge clk);
        host_req[2] = 1'b1;
        #1;
        checks++;
        if (gnt_v !== 3'b100) begin
            errors++;
            $display("FAIL skip_first got %b exp 100", gnt_v);
        end
        @(negedge clk);
        #1;
        checks++;
        if (gnt_v !== 3'b001) begin
            errors++;
            $display("FAIL skip_wrap got %b exp 001", gnt_v);
        end
        @(negedge clk);
        host_req[1] = 1'b1;
        #1;
        checks++;
        if (gnt_v !== 3'b010) begin
            errors++;
            $display("FAIL skip_ptr1 got %b exp 010", gnt_v);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_decode_err();
        do_reset();
        dev_rdata[0] = 32'h5555_5555;
        host_req[1]   = 1'b1;
        host_we[1]    = 1'b1;
        host_be[1]    = 4'hF;
        host_addr[1]  = 32'h0002_0000;
        host_wdata[1] = 32'hCAFE_0001;
        #1;
`ifdef BUS_RR_DECODE_ERR_EN
        checks++;
        if (gnt_v !== 3'b010 || dreq_v !== 2'b00) begin
            errors++;
            $display("FAIL decerr_req got gnt=%b dreq=%b exp gnt=010 dreq=00", gnt_v, dreq_v);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rvalid_v !== 3'b010 || err_v !== 3'b010 || host_rdata[1] !== 32'h0) begin
            errors++;
            $display("FAIL decerr_resp got rv=%b err=%b rdata=%h exp rv=010 err=010 rdata=0",
                     rvalid_v, err_v, host_rdata[1]);
        end
`else
        checks++;
        if (gnt_v !== 3'b010 || dreq_v !== 2'b01 || dev_we[0] !== 1'b1 || dev_wdata[0] !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL legacy_req got gnt=%b dreq=%b we=%b wdata=%h exp gnt=010 dreq=01 we=1 wdata=cafe0001",
                     gnt_v, dreq_v, dev_we[0], dev_wdata[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rvalid_v !== 3'b010 || err_v !== 3'b000 || host_rdata[1] !== 32'h5555_5555) begin
            errors++;
            $display("FAIL legacy_resp got rv=%b err=%b rdata=%h exp rv=010 err=000 rdata=55555555",
                     rvalid_v, err_v, host_rdata[1]);
        end
`endif
        @(negedge clk);
        idle();
    endtask

    task automatic test_byte_write();
        do_reset();
        host_req[2]   = 1'b1;
        host_we[2]    = 1'b1;
        host_be[2]    = 4'b0010;
        host_addr[2]  = 32'h0000_0008;
        host_wdata[2] = 32'h0000_AB00;
        #1;
        checks++;
        if (gnt_v !== 3'b100 || dreq_v !== 2'b01 || dev_we[0] !== 1'b1 || dev_be[0] !== 4'b0010 ||
            dev_addr[0] !== 32'h0000_0008 || dev_wdata[0] !== 32'h0000_AB00) begin
            errors++;
            $display("FAIL byte_write got gnt=%b dreq=%b we=%b be=%b addr=%h wdata=%h exp 100 01 1 0010 00000008 0000ab00",
                     gnt_v, dreq_v, dev_we[0], dev_be[0], dev_addr[0], dev_wdata[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rvalid_v !== 3'b100) begin
            errors++;
            $display("FAIL byte_write_rvalid got %b exp 100", rvalid_v);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_midop();
        do_reset();
        host_req[0]  = 1'b1;
        host_addr[0] = 32'h0000_0004;
        #1;
        checks++;
        if (gnt_v !== 3'b001) begin
            errors++;
            $display("FAIL midop_gnt got %b exp 001", gnt_v);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle();
        #1;
        checks++;
        if (rvalid_v !== 3'b000) begin
            errors++;
            $display("FAIL midop_rvalid got %b exp 000", rvalid_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({gnt_v, rvalid_v, err_v, dreq_v} !== '0) begin
            errors++;
            $display("FAIL midop_release got gnt=%b rv=%b err=%b dreq=%b exp all 0",
                     gnt_v, rvalid_v, err_v, dreq_v);
        end
        @(negedge clk);
        for (int h = 0; h < NH; h++) host_req[h] = 1'b1;
        #1;
        checks++;
        if (gnt_v !== 3'b001) begin
            errors++;
            $display("FAIL midop_ptr got %b exp 001", gnt_v);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        cfg_base[0] = 32'h0000_0000;
        cfg_mask[0] = 32'hFFFF_0000;
        cfg_base[1] = 32'h0001_0000;
        cfg_mask[1] = 32'hFFFF_0000;
        test_reset();
        test_single_read();
        test_fairness();
        test_ptr_skip();
        test_decode_err();
        test_byte_write();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_rr.md
# bus_rr

Parametrised multi-host, multi-device interconnect with round-robin arbitration, registered response routing and decode-error reporting. It sits between the core/DMA hosts and the memory-mapped peripherals (RAM, UART, hwtimer) and replaces the fixed-priority single-cycle interconnect. It carries one transaction per cycle. The response returns exactly one cycle after grant and is routed back to the granted host only.

## Interface
Parameters:
- NrHosts, 2, number of hosts (≥1)
- NrDevices, 2, number of devices (≥1)
- DataWidth, 32, data bus width (multiple of 8)
- AddressWidth, 32, address width

Ports (per-host/per-device signals are unpacked arrays of size NrHosts/NrDevices):
- clk_i  in  1  clock; one clock, all logic on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- host_req_i  in  1 [NrHosts]  request
- host_we_i  in  1 [NrHosts]  1 = write
- host_be_i  in  DataWidth/8 [NrHosts]  byte enables
- host_addr_i  in  AddressWidth [NrHosts]  address
- host_wdata_i  in  DataWidth [NrHosts]  write data
- host_gnt_o  out  1 [NrHosts]  grant, same cycle as request
- host_rvalid_o  out  1 [NrHosts]  response valid, one cycle after grant
- host_rdata_o  out  DataWidth [NrHosts]  read data, qualified by rvalid
- host_err_o  out  1 [NrHosts]  decode error, qualified by rvalid
- device_req_o  out  1 [NrDevices]  request to device
- device_we_o  out  1 [NrDevices]
- device_be_o  out  DataWidth/8 [NrDevices]
- device_addr_o  out  AddressWidth [NrDevices]
- device_wdata_o  out  DataWidth [NrDevices]
- device_rdata_i  in  DataWidth [NrDevices]  read data, valid the cycle after device_req_o
- cfg_device_addr_base  in  AddressWidth [NrDevices]  device base
- cfg_device_addr_mask  in  AddressWidth [NrDevices]  device mask (1 = compared bit)

## Operation
- Arbitration: round-robin. Register `rr_ptr` is max(1, clog2(NrHosts)) bits wide. The winner is the first requesting host at index ≥ `rr_ptr`, scanning upward with wrap to 0.
- After any grant to host h: `rr_ptr` ← h+1, or 0 if h = NrHosts-1. This handles non-power-of-two NrHosts. With no request, `rr_ptr` holds.
- Decode: device d matches when (addr & mask[d]) == base[d]. The lowest matching index wins.
- Request path (combinational): only the matched device sees the winner's req/we/be/addr/wdata. All other device outputs are 0. host_gnt_o is 1 only for the winner.
- Response registers are loaded on a grant: `resp_valid`, `resp_host`, `resp_dev`, `resp_err`. With no grant, `resp_valid` ← 0.
- Response path:
  - host_rvalid_o[resp_host] = resp_valid.
  - host_rdata_o[resp_host] = device_rdata_i[resp_dev], or 0 if `resp_err`.
  - host_err_o[resp_host] = resp_err.
  - All other hosts' outputs are 0.
- Writes also receive rvalid. rdata is don't-care for writes, but the bus still drives the routed value.
- Reset values: rr_ptr=0, resp_valid=0, resp_host=0, resp_dev=0, resp_err=0. All *_o are 0 while reset is asserted, given idle inputs.

## Timing
- Grant is in cycle N, combinational from host_req_i. Response (rvalid/rdata/err) is in cycle N+1. Back-to-back grants every cycle are supported, with full throughput.
- Simultaneous requests from all hosts: grants rotate 0,1,…,NrHosts-1,0,… one per cycle.
- A host that drops its request before grant loses nothing. No state is kept for ungranted requests.
- Reset asserted mid-transaction: any pending response is dropped and rvalid stays 0. Hosts must reissue.
- Hosts must not change cfg_* while any request is outstanding.

## Configuration
- BUS_RR_DECODE_ERR_EN defined:
  - An unmatched address is granted and no device_req_o is asserted.
  - The next cycle gives rvalid=1, err=1, rdata=0.
- BUS_RR_DECODE_ERR_EN undefined:
  - An unmatched address routes to device 0, as a legacy default.
  - host_err_o is tied to 0 and resp_err logic is removed.

## Test plan
Setup for all scenarios: NrHosts=3, NrDevices=2, base0=0x0000_0000/mask 0xFFFF_0000, base1=0x0001_0000/mask 0xFFFF_0000.
- Single read: host0 reads 0x0001_0004, device1 returns 0xDEAD_BEEF → gnt[0] in cycle N; rvalid[0]=1 and rdata[0]=0xDEAD_BEEF in N+1; device0 req stays 0.
- Fairness: hosts 0,1,2 request continuously for 6 cycles → grant order 0,1,2,0,1,2; each rvalid lands one cycle after its grant on the right host.
- Pointer skip: rr_ptr=1 with only hosts 0 and 2 requesting → host2 granted, then host0; rr_ptr becomes 0, then 1.
- Decode error (macro on): host1 writes 0x0002_0000 → gnt[1]=1, no device_req; next cycle rvalid[1]=1, err[1]=1, rdata[1]=0. With the macro off, device0 receives the write and err=0.
- Byte write: host2 writes be=4'b0010, wdata=0x0000_AB00 to 0x0000_0008 → device0 sees be=0010, addr=0x0000_0008, we=1.
- Reset mid-op: host0 granted in cycle N, rst_ni low in N+1 → no rvalid; all outputs 0 and rr_ptr=0 after release.
